// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim_pkg.sv
// Shared types and constants for the dffnrnq stimulus sequencer.
// Holds the FSM state set, the LFSR taps and the checker constants.
package gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRIME_HI = 4'd1,
    ST_PRIME_LO = 4'd2,
    ST_RST_A    = 4'd3,
    ST_RST_B    = 4'd4,
    ST_RECOVER  = 4'd5,
    ST_B_SETUP  = 4'd6,
    ST_B_FALL   = 4'd7,
    ST_B_HOLD   = 4'd8,
    ST_B_CHECK  = 4'd9,
    ST_DONE     = 4'd10
  } state_e;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10 of a left-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int ERR_CNT_W = 8;

  localparam logic [7:0] FIRST_ERR_NONE = 8'hFF;

  // Bit shifted into position 0 on the next LFSR step.
  function automatic logic lfsr_fb(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__stim_lfsr16.sv
// 16-bit Fibonacci LFSR producing the capture pattern; output bit is Q[0].
// LOAD takes priority over STEP.
module gf180mcu_fd_sc_mcu7t5v0__stim_lfsr16
  import gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] SEED,
  input  logic        STEP,
  output logic [15:0] Q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (LOAD) begin
      lfsr_d = SEED;
    end else if (STEP) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb(lfsr_q)};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Q = lfsr_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim.sv
// Stimulus sequencer for one negedge, async-low-reset D flop: primes it, checks
// reset, then captures and checks an LFSR pattern, reporting pass/fail.
module gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim
  import gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim_pkg::*;
#(
  parameter int          NBITS = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Q_I,
  output logic       CLKN_O,
  output logic       D_O,
  output logic       RN_O,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic       RST_FAIL,
  output logic [7:0] ERR_CNT,
  output logic [7:0] FIRST_ERR_IDX
);

  localparam logic [7:0] LAST_IDX = 8'(NBITS - 1);

  state_e                 state_q, state_d;
  logic                   start_q;
  logic [7:0]             bit_idx_q, bit_idx_d;
  logic                   clkn_q, clkn_d;
  logic                   d_q, d_d;
  logic                   rn_q, rn_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   rst_fail_q, rst_fail_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [7:0]             first_err_q, first_err_d;

  logic                   lfsr_load;
  logic                   lfsr_step;
  logic [15:0]            lfsr_q;
  logic                   setup_bit;

  gf180mcu_fd_sc_mcu7t5v0__stim_lfsr16 u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (lfsr_load),
    .SEED (SEED),
    .STEP (lfsr_step),
    .Q    (lfsr_q)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    pass_d      = pass_q;
    rst_fail_d  = rst_fail_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d     = ST_PRIME_HI;
          lfsr_load   = 1'b1;
          pass_d      = 1'b0;
          rst_fail_d  = 1'b0;
          err_cnt_d   = '0;
          first_err_d = FIRST_ERR_NONE;
        end
      end
      ST_PRIME_HI: state_d = ST_PRIME_LO;
      ST_PRIME_LO: state_d = ST_RST_A;
      ST_RST_A:    state_d = ST_RST_B;
      ST_RST_B: begin
        // RN has been low for two cycles, so Q must already read 0.
        if (Q_I != 1'b0) begin
          rst_fail_d = 1'b1;
        end
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        bit_idx_d = '0;
        state_d   = ST_B_SETUP;
      end
      ST_B_SETUP: state_d = ST_B_FALL;
      ST_B_FALL:  state_d = ST_B_HOLD;
      ST_B_HOLD:  state_d = ST_B_CHECK;
      ST_B_CHECK: begin
        lfsr_step = 1'b1;
        if (Q_I != d_q) begin
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (first_err_q == FIRST_ERR_NONE) begin
            first_err_d = bit_idx_q;
          end
        end
        if (bit_idx_q < LAST_IDX) begin
          bit_idx_d = bit_idx_q + 8'd1;
          state_d   = ST_B_SETUP;
        end else begin
          // Verdict lands together with DONE so both are valid in the same cycle.
          pass_d  = (err_cnt_d == '0) && !rst_fail_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The LFSR steps on the same edge that re-enters B_SETUP, so the next
  // pattern bit has to be taken from the feedback rather than lfsr_q[0].
  assign setup_bit = (state_q == ST_B_CHECK) ? lfsr_fb(lfsr_q) : lfsr_q[0];

  always_comb begin
    clkn_d = 1'b1;
    rn_d   = 1'b1;
    d_d    = d_q;
    unique case (state_d)
      ST_IDLE:     d_d = 1'b0;
      ST_PRIME_HI: d_d = 1'b1;
      ST_PRIME_LO: begin
        d_d    = 1'b1;
        clkn_d = 1'b0;
      end
      ST_RST_A:    rn_d = 1'b0;
      ST_RST_B:    rn_d = 1'b0;
      ST_RECOVER:  d_d = 1'b0;
      ST_B_SETUP:  d_d = setup_bit;
      ST_B_FALL:   clkn_d = 1'b0;
      ST_B_HOLD:   d_d = d_q;
      ST_B_CHECK:  d_d = d_q;
      ST_DONE:     d_d = 1'b0;
      default:     d_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      bit_idx_q   <= '0;
      clkn_q      <= 1'b1;
      d_q         <= 1'b0;
      rn_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      rst_fail_q  <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= FIRST_ERR_NONE;
    end else begin
      state_q     <= state_d;
      start_q     <= START;
      bit_idx_q   <= bit_idx_d;
      clkn_q      <= clkn_d;
      d_q         <= d_d;
      rn_q        <= rn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      rst_fail_q  <= rst_fail_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign CLKN_O        = clkn_q;
  assign D_O           = d_q;
  assign RN_O          = rn_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PASS          = pass_q;
  assign RST_FAIL      = rst_fail_q;
  assign ERR_CNT       = err_cnt_q;
  assign FIRST_ERR_IDX = first_err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim.sv
// Directed bench: loops the sequencer back through a behavioural dffnrnq model
// (or a stuck-at Q) and checks run timing, verdicts and reset behaviour.
module tb_gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       q_i, q_i1;
  logic       clkn_o, d_o, rn_o, busy, done, pass, rst_fail;
  logic [7:0] err_cnt, first_err;
  logic       clkn_o1, d_o1, rn_o1, busy1, done1, pass1, rst_fail1;
  logic [7:0] err_cnt1, first_err1;

  logic       flop_q, flop_q1;
  int         mode;
  int         falls, falls1;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim #(.NBITS(16), .SEED(16'hACE1)) dut (
    .CLK(clk), .RST(rst), .START(start), .Q_I(q_i),
    .CLKN_O(clkn_o), .D_O(d_o), .RN_O(rn_o), .BUSY(busy), .DONE(done),
    .PASS(pass), .RST_FAIL(rst_fail), .ERR_CNT(err_cnt), .FIRST_ERR_IDX(first_err)
  );

  gf180mcu_fd_sc_mcu7t5v0__dffnrnq_stim #(.NBITS(1), .SEED(16'hACE1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .Q_I(q_i1),
    .CLKN_O(clkn_o1), .D_O(d_o1), .RN_O(rn_o1), .BUSY(busy1), .DONE(done1),
    .PASS(pass1), .RST_FAIL(rst_fail1), .ERR_CNT(err_cnt1), .FIRST_ERR_IDX(first_err1)
  );

  // Behavioural dffnrnq: captures D on CLKN fall, clears while RN is low.
  always @(negedge clkn_o or negedge rn_o) begin
    if (!rn_o) flop_q <= 1'b0;
    else       flop_q <= d_o;
  end
  always @(negedge clkn_o1 or negedge rn_o1) begin
    if (!rn_o1) flop_q1 <= 1'b0;
    else        flop_q1 <= d_o1;
  end

  always @(negedge clkn_o)  falls  = falls + 1;
  always @(negedge clkn_o1) falls1 = falls1 + 1;

  // mode 0: real flop, 1: Q stuck at 0, 2: Q stuck at 1
  assign q_i  = (mode == 0) ? flop_q : (mode == 2);
  assign q_i1 = flop_q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses START so that it is sampled at edge 0; returns just after edge 0.
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int first_done, second_done, done_count;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
    falls = 0; falls1 = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk1("rst_clkn", clkn_o, 1'b1);
    chk1("rst_d", d_o, 1'b0);
    chk1("rst_rn", rn_o, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_pass", pass, 1'b0);
    chk1("rst_rstfail", rst_fail, 1'b0);
    chk8("rst_errcnt", err_cnt, 8'd0);
    chk8("rst_firsterr", first_err, 8'hFF);

    // Run 1: healthy flop
    mode = 0;
    falls = 0;
    start_pulse();
    chk1("r1_busy_e0", busy, 1'b0);
    tick();
    chk1("r1_busy_e1", busy, 1'b1);
    repeat (68) tick();
    chk1("r1_done_e69", done, 1'b0);
    chk1("r1_busy_e69", busy, 1'b1);
    tick();
    chk1("r1_done_e70", done, 1'b1);
    chk1("r1_busy_e70", busy, 1'b0);
    chk1("r1_pass", pass, 1'b1);
    chk8("r1_errcnt", err_cnt, 8'd0);
    chk1("r1_rstfail", rst_fail, 1'b0);
    chk8("r1_firsterr", first_err, 8'hFF);
    chki("r1_clkn_falls", falls, 17);
    tick();
    chk1("r1_done_e71", done, 1'b0);
    chk1("r1_pass_held", pass, 1'b1);

    // Run 2: Q stuck at 0; pattern 1111_0010_0010_1010 (bit0 first) has 8 ones
    mode = 1;
    start_pulse();
    tick();
    chk1("r2_pass_cleared", pass, 1'b0);
    repeat (69) tick();
    chk1("r2_done", done, 1'b1);
    chk1("r2_rstfail", rst_fail, 1'b0);
    chk8("r2_errcnt", err_cnt, 8'd8);
    chk8("r2_firsterr", first_err, 8'd0);
    chk1("r2_pass", pass, 1'b0);
    tick();

    // Run 3: Q stuck at 1; 8 zeros, first zero at bit 4
    mode = 2;
    start_pulse();
    repeat (70) tick();
    chk1("r3_done", done, 1'b1);
    chk1("r3_rstfail", rst_fail, 1'b1);
    chk8("r3_errcnt", err_cnt, 8'd8);
    chk8("r3_firsterr", first_err, 8'd4);
    chk1("r3_pass", pass, 1'b0);
    tick();

    // Run 4: reset mid-run; bits 0..4 checked by edge 29 (four ones vs stuck 0)
    mode = 1;
    start_pulse();
    repeat (29) tick();
    chk8("r4_errcnt_e29", err_cnt, 8'd4);
    chk1("r4_busy_e29", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("r4_clkn", clkn_o, 1'b1);
    chk1("r4_rn", rn_o, 1'b1);
    chk1("r4_d", d_o, 1'b0);
    chk1("r4_busy", busy, 1'b0);
    chk8("r4_errcnt", err_cnt, 8'd0);
    chk8("r4_firsterr", first_err, 8'hFF);
    mode = 0;
    tick();
    start_pulse();
    repeat (70) tick();
    chk1("r4b_done", done, 1'b1);
    chk1("r4b_pass", pass, 1'b1);
    tick();

    // Run 5: START held high for 200 edges
    first_done = -1; second_done = -1; done_count = 0;
    start = 1'b1;
    for (int e = 0; e < 200; e++) begin
      tick();
      if (done) begin
        done_count++;
        if (first_done < 0) first_done = e;
        else if (second_done < 0) second_done = e;
      end
      if (e == 71) chk1("r5_idle_gap", busy, 1'b0);
      if (e == 72) chk1("r5_rerun_busy", busy, 1'b1);
      if (e == 141) chk1("r5_pass2", pass, 1'b1);
    end
    start = 1'b0;
    chki("r5_first_done", first_done, 70);
    chki("r5_second_done", second_done, 141);
    chki("r5_done_count", done_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Run 6: NBITS=1 instance
    falls1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (9) tick();
    chk1("n1_done_e9", done1, 1'b0);
    chk1("n1_busy_e9", busy1, 1'b1);
    tick();
    chk1("n1_done_e10", done1, 1'b1);
    chk1("n1_busy_e10", busy1, 1'b0);
    chk1("n1_pass", pass1, 1'b1);
    chk1("n1_rstfail", rst_fail1, 1'b0);
    chk8("n1_errcnt", err_cnt1, 8'd0);
    chk8("n1_firsterr", first_err1, 8'hFF);
    chki("n1_clkn_falls", falls1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
